// File: rtl/bmp_blit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bmp_blit: copies a ROM bitmap (draw/erase) or a solid rectangle (fill)     |
// | into video memory, one clipped pixel write per clock.                      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module bmp_blit #(
  parameter int                 SCR_W   = 640,
  parameter int                 SCR_H   = 480,
  parameter int                 PIX_W   = 6,
  parameter int                 NUM_IMG = 4,
  parameter int                 ROM_AW  = 16,
  parameter logic [PIX_W-1:0]   TRANSP  = 6'h24,
  localparam int                AW      = $clog2(SCR_W*SCR_H),
  localparam int                IW      = $clog2(NUM_IMG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_vld,
  input  logic [1:0]        cmd_op,
  input  logic [IW-1:0]     cmd_indx,
  input  logic [9:0]        xloc,
  input  logic [8:0]        yloc,
  input  logic [9:0]        fill_w,
  input  logic [8:0]        fill_h,
  input  logic [PIX_W-1:0]  fill_color,
  output logic [ROM_AW-1:0] rom_addr,
  output logic [IW-1:0]     rom_sel,
  input  logic [PIX_W-1:0]  rom_data,
  output logic [AW-1:0]     waddr,
  output logic [PIX_W-1:0]  wdata,
  output logic              we,
  output logic              busy,
  output logic              done
);

  typedef enum logic [3:0] {
    S_IDLE, S_HDR0, S_HDR1, S_HDR2, S_HDR3, S_SIZE, S_PIX, S_FILL, S_DONE
  } state_t;

  localparam logic [1:0]  OP_DRAW = 2'b00;
  localparam logic [1:0]  OP_FILL = 2'b10;
  localparam logic [1:0]  OP_NONE = 2'b11;
  localparam logic [12:0] SCR_W_C = 13'(SCR_W);
  localparam logic [12:0] SCR_H_C = 13'(SCR_H);

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [IW-1:0]      rom_sel_q, rom_sel_d;
  logic [ROM_AW-1:0]  rom_addr_q, rom_addr_d;
  logic [9:0]         x0_q, x0_d;
  logic [8:0]         y0_q, y0_d;
  logic [PIX_W-1:0]   color_q, color_d;
  logic [PIX_W-1:0]   w_hi_q, w_hi_d;
  logic [PIX_W-1:0]   h_hi_q, h_hi_d;
  logic [11:0]        w_q, w_d, h_q, h_d;
  logic [11:0]        col_q, col_d, row_q, row_d;
  logic               in_q, in_d;
  logic [AW-1:0]      cur_addr_q, cur_addr_d;
  logic [AW-1:0]      last_waddr_q, last_waddr_d;

  logic               accept;
  logic               last_pix;
  logic [11:0]        h_hdr;
  logic [9:0]         base_x;
  logic [8:0]         base_y;
  logic [12:0]        nx, ny;

  // Counters and the in-screen/address registers always describe the pixel
  // being processed this cycle, so they are loaded one cycle ahead from *_d.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rom_sel_d  = rom_sel_q;
    rom_addr_d = rom_addr_q;
    x0_d       = x0_q;
    y0_d       = y0_q;
    color_d    = color_q;
    w_hi_d     = w_hi_q;
    h_hi_d     = h_hi_q;
    w_d        = w_q;
    h_d        = h_q;
    col_d      = col_q;
    row_d      = row_q;
    base_x     = x0_q;
    base_y     = y0_q;

    accept   = (state_q == S_IDLE || state_q == S_DONE) && cmd_vld && (cmd_op != OP_NONE);
    last_pix = (col_q == w_q - 12'd1) && (row_q == h_q - 12'd1);
    h_hdr    = (12'(h_hi_q) << 6) + 12'(rom_data);

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          op_d      = cmd_op;
          rom_sel_d = cmd_indx;
          x0_d      = xloc;
          y0_d      = yloc;
          color_d   = fill_color;
          base_x    = xloc;
          base_y    = yloc;
          col_d     = '0;
          row_d     = '0;
          if (cmd_op == OP_FILL) begin
            w_d     = 12'(fill_w);
            h_d     = 12'(fill_h);
            state_d = (fill_w == '0 || fill_h == '0) ? S_DONE : S_FILL;
          end else begin
            rom_addr_d = '0;
            state_d    = S_HDR0;
          end
        end
      end
      S_HDR0: begin
        rom_addr_d = rom_addr_q + 1'b1;
        state_d    = S_HDR1;
      end
      S_HDR1: begin
        rom_addr_d = rom_addr_q + 1'b1;
        w_hi_d     = rom_data;
        state_d    = S_HDR2;
      end
      S_HDR2: begin
        rom_addr_d = rom_addr_q + 1'b1;
        w_d        = (12'(w_hi_q) << 6) + 12'(rom_data);
        state_d    = S_HDR3;
      end
      S_HDR3: begin
        rom_addr_d = rom_addr_q + 1'b1;
        h_hi_d     = rom_data;
        state_d    = S_SIZE;
      end
      S_SIZE: begin
        rom_addr_d = rom_addr_q + 1'b1;
        h_d        = h_hdr;
        col_d      = '0;
        row_d      = '0;
        state_d    = (w_q == '0 || h_hdr == '0) ? S_DONE : S_PIX;
      end
      S_PIX, S_FILL: begin
        if (state_q == S_PIX) begin
          rom_addr_d = rom_addr_q + 1'b1;
        end
        if (last_pix) begin
          state_d = S_DONE;
        end else if (col_q == w_q - 12'd1) begin
          col_d = '0;
          row_d = row_q + 12'd1;
        end else begin
          col_d = col_q + 12'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    nx         = 13'(base_x) + 13'(col_d);
    ny         = 13'(base_y) + 13'(row_d);
    in_d       = (nx < SCR_W_C) && (ny < SCR_H_C);
    cur_addr_d = in_d ? AW'(32'(ny) * 32'(SCR_W) + 32'(nx)) : cur_addr_q;
  end

  always_comb begin
    we    = in_q && ((state_q == S_PIX && rom_data != TRANSP) || state_q == S_FILL);
    wdata = '0;
    if (state_q == S_FILL) begin
      wdata = color_q;
    end else if (state_q == S_PIX && op_q == OP_DRAW) begin
      wdata = rom_data;
    end
    // Transparent in-screen pixels must not disturb the visible address.
    waddr        = we ? cur_addr_q : last_waddr_q;
    last_waddr_d = waddr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      rom_sel_q    <= '0;
      rom_addr_q   <= '0;
      x0_q         <= '0;
      y0_q         <= '0;
      color_q      <= '0;
      w_hi_q       <= '0;
      h_hi_q       <= '0;
      w_q          <= '0;
      h_q          <= '0;
      col_q        <= '0;
      row_q        <= '0;
      in_q         <= 1'b0;
      cur_addr_q   <= '0;
      last_waddr_q <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      rom_sel_q    <= rom_sel_d;
      rom_addr_q   <= rom_addr_d;
      x0_q         <= x0_d;
      y0_q         <= y0_d;
      color_q      <= color_d;
      w_hi_q       <= w_hi_d;
      h_hi_q       <= h_hi_d;
      w_q          <= w_d;
      h_q          <= h_d;
      col_q        <= col_d;
      row_q        <= row_d;
      in_q         <= in_d;
      cur_addr_q   <= cur_addr_d;
      last_waddr_q <= last_waddr_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign rom_sel  = rom_sel_q;
  assign busy     = !(state_q == S_IDLE || state_q == S_DONE);
  assign done     = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_bmp_blit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_bmp_blit: directed self-checking bench for bmp_blit with ROM models.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_bmp_blit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_vld = 1'b0;
  logic [1:0]  cmd_op = 2'b11;
  logic [1:0]  cmd_indx = '0;
  logic [9:0]  xloc = '0;
  logic [8:0]  yloc = '0;
  logic [9:0]  fill_w = '0;
  logic [8:0]  fill_h = '0;
  logic [5:0]  fill_color = '0;
  logic [15:0] rom_addr;
  logic [1:0]  rom_sel;
  logic [5:0]  rom_data;
  logic [18:0] waddr;
  logic [5:0]  wdata;
  logic        we, busy, done;

  logic [5:0]  rom_mem [0:3][0:63];
  int          vectors = 0;
  int          miscompares = 0;

  bmp_blit dut (
    .clk(clk), .rst(rst), .cmd_vld(cmd_vld), .cmd_op(cmd_op), .cmd_indx(cmd_indx),
    .xloc(xloc), .yloc(yloc), .fill_w(fill_w), .fill_h(fill_h), .fill_color(fill_color),
    .rom_addr(rom_addr), .rom_sel(rom_sel), .rom_data(rom_data),
    .waddr(waddr), .wdata(wdata), .we(we), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    rom_data <= (rom_addr < 16'd64) ? rom_mem[rom_sel][rom_addr[5:0]] : 6'd0;

  task automatic init_rom();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 64; j++)
        rom_mem[i][j] = 6'd0;
    // ROM0: W=0, H=2; ROM1: 3x2 pixels 1..6; ROM2: same with a transparent pixel 1
    rom_mem[0][3] = 6'd2;
    rom_mem[1][1] = 6'd3; rom_mem[1][3] = 6'd2;
    rom_mem[2][1] = 6'd3; rom_mem[2][3] = 6'd2;
    for (int k = 0; k < 6; k++) begin
      rom_mem[1][4+k] = 6'(k + 1);
      rom_mem[2][4+k] = 6'(k + 1);
    end
    rom_mem[2][5] = 6'h24;
    // ROM3: 4x2 pixels 7..14
    rom_mem[3][1] = 6'd4; rom_mem[3][3] = 6'd2;
    for (int k = 0; k < 8; k++) rom_mem[3][4+k] = 6'(k + 7);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Presents a command in the current cycle (t0) and returns at t1.
  task automatic issue(input logic [1:0] op, input logic [1:0] idx, input logic [9:0] x,
                       input logic [8:0] y, input logic [9:0] fw, input logic [8:0] fh,
                       input logic [5:0] c);
    cmd_vld = 1'b1; cmd_op = op; cmd_indx = idx; xloc = x; yloc = y;
    fill_w = fw; fill_h = fh; fill_color = c;
    step();
    cmd_vld = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step(); step();
    vectors++; if (busy !== 1'b0 || done !== 1'b0 || we !== 1'b0) begin
      miscompares++; $display("FAIL reset_flags busy=%b done=%b we=%b required 0 0 0", busy, done, we); end
    vectors++; if (rom_addr !== 16'd0 || rom_sel !== 2'd0) begin
      miscompares++; $display("FAIL reset_rom rom_addr=%0d rom_sel=%0d required 0 0", rom_addr, rom_sel); end
    vectors++; if (waddr !== 19'd0 || wdata !== 6'd0) begin
      miscompares++; $display("FAIL reset_wr waddr=%0d wdata=%0d required 0 0", waddr, wdata); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_draw();
    int exp_addr [6] = '{12810, 12811, 12812, 13450, 13451, 13452};
    issue(2'b00, 2'd1, 10'd10, 9'd20, 10'd0, 9'd0, 6'd0);
    for (int c = 1; c <= 12; c++) begin
      if (c <= 5) begin
        vectors++; if (busy !== 1'b1 || rom_addr !== 16'(c - 1)) begin
          miscompares++; $display("FAIL draw_hdr t%0d busy=%b rom_addr=%0d required 1 %0d", c, busy, rom_addr, c - 1); end
      end
      if (c >= 6 && c <= 11) begin
        vectors++; if (we !== 1'b1 || waddr !== 19'(exp_addr[c-6]) || wdata !== 6'(c - 5)) begin
          miscompares++; $display("FAIL draw_pix t%0d we=%b waddr=%0d wdata=%0d required 1 %0d %0d",
                                  c, we, waddr, wdata, exp_addr[c-6], c - 5); end
      end else begin
        vectors++; if (we !== 1'b0) begin
          miscompares++; $display("FAIL draw_idle t%0d we=%b required 0", c, we); end
      end
      vectors++; if (done !== (c == 12) || (c == 12 && busy !== 1'b0)) begin
        miscompares++; $display("FAIL draw_done t%0d done=%b busy=%b required done=%b", c, done, busy, c == 12); end
      if (c < 12) step();
    end
    step();
  endtask

  task automatic test_transparent();
    int         exp_addr [6] = '{12810, 12811, 12812, 13450, 13451, 13452};
    logic [5:0] pix [6] = '{6'd1, 6'h24, 6'd3, 6'd4, 6'd5, 6'd6};
    for (int p = 0; p < 2; p++) begin
      issue((p == 0) ? 2'b00 : 2'b01, 2'd2, 10'd10, 9'd20, 10'd0, 9'd0, 6'd0);
      for (int c = 1; c <= 12; c++) begin
        if (c >= 6 && c <= 11) begin
          if (pix[c-6] == 6'h24) begin
            vectors++; if (we !== 1'b0 || waddr !== 19'd12810) begin
              miscompares++; $display("FAIL transp_skip op%0d t%0d we=%b waddr=%0d required 0 12810", p, c, we, waddr); end
          end else begin
            vectors++; if (we !== 1'b1 || waddr !== 19'(exp_addr[c-6]) || wdata !== ((p == 0) ? pix[c-6] : 6'd0)) begin
              miscompares++; $display("FAIL transp_pix op%0d t%0d we=%b waddr=%0d wdata=%0d required 1 %0d %0d",
                                      p, c, we, waddr, wdata, exp_addr[c-6], (p == 0) ? pix[c-6] : 6'd0); end
          end
        end
        if (c == 12) begin
          vectors++; if (done !== 1'b1) begin
            miscompares++; $display("FAIL transp_done op%0d done=%b required 1", p, done); end
        end
        if (c < 12) step();
      end
      step();
    end
  endtask

  task automatic test_clip();
    issue(2'b00, 2'd3, 10'd638, 9'd479, 10'd0, 9'd0, 6'd0);
    for (int c = 1; c <= 14; c++) begin
      if (c == 6 || c == 7) begin
        vectors++; if (we !== 1'b1 || waddr !== 19'(307192 + c) || wdata !== 6'(c + 1)) begin
          miscompares++; $display("FAIL clip_pix t%0d we=%b waddr=%0d wdata=%0d required 1 %0d %0d",
                                  c, we, waddr, wdata, 307192 + c, c + 1); end
      end else begin
        vectors++; if (we !== 1'b0) begin
          miscompares++; $display("FAIL clip_off t%0d we=%b required 0", c, we); end
      end
      vectors++; if (done !== (c == 14)) begin
        miscompares++; $display("FAIL clip_done t%0d done=%b required %b", c, done, c == 14); end
      if (c < 14) step();
    end
    step();
  endtask

  task automatic test_fill();
    int exp_addr [4] = '{0, 1, 640, 641};
    issue(2'b10, 2'd0, 10'd0, 9'd0, 10'd2, 9'd2, 6'h3F);
    for (int c = 1; c <= 5; c++) begin
      if (c <= 4) begin
        vectors++; if (we !== 1'b1 || waddr !== 19'(exp_addr[c-1]) || wdata !== 6'h3F || busy !== 1'b1) begin
          miscompares++; $display("FAIL fill_pix t%0d we=%b waddr=%0d wdata=%0d busy=%b required 1 %0d 63 1",
                                  c, we, waddr, wdata, busy, exp_addr[c-1]); end
      end else begin
        vectors++; if (we !== 1'b0 || done !== 1'b1) begin
          miscompares++; $display("FAIL fill_done we=%b done=%b required 0 1", we, done); end
      end
      if (c < 5) step();
    end
    step();
    issue(2'b10, 2'd0, 10'd3, 9'd3, 10'd0, 9'd5, 6'h3F);
    vectors++; if (done !== 1'b1 || we !== 1'b0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL fill_zero done=%b we=%b busy=%b required 1 0 0", done, we, busy); end
    step();
    vectors++; if (done !== 1'b0) begin
      miscompares++; $display("FAIL fill_zero_after done=%b required 0", done); end
    issue(2'b00, 2'd0, 10'd1, 9'd1, 10'd0, 9'd0, 6'd0);
    for (int c = 1; c <= 6; c++) begin
      vectors++; if (we !== 1'b0 || done !== (c == 6)) begin
        miscompares++; $display("FAIL draw_zero t%0d we=%b done=%b required 0 %b", c, we, done, c == 6); end
      if (c < 6) step();
    end
    step();
  endtask

  task automatic test_back_to_back();
    int exp_addr [6] = '{12810, 12811, 12812, 13450, 13451, 13452};
    issue(2'b00, 2'd1, 10'd10, 9'd20, 10'd0, 9'd0, 6'd0);
    for (int c = 1; c <= 12; c++) begin
      if (c >= 6 && c <= 11) begin
        vectors++; if (we !== 1'b1 || waddr !== 19'(exp_addr[c-6]) || wdata !== 6'(c - 5)) begin
          miscompares++; $display("FAIL busy_ignore t%0d we=%b waddr=%0d wdata=%0d required 1 %0d %0d",
                                  c, we, waddr, wdata, exp_addr[c-6], c - 5); end
      end
      if (c == 3) begin
        cmd_vld = 1'b1; cmd_op = 2'b10; xloc = 10'd0; yloc = 9'd0;
        fill_w = 10'd1; fill_h = 9'd1; fill_color = 6'h11;
      end
      if (c == 4) cmd_vld = 1'b0;
      if (c < 12) begin
        vectors++; if (done !== 1'b0) begin
          miscompares++; $display("FAIL busy_early_done t%0d done=%b required 0", c, done); end
        step();
      end
    end
    vectors++; if (done !== 1'b1) begin
      miscompares++; $display("FAIL b2b_done done=%b required 1", done); end
    issue(2'b10, 2'd0, 10'd5, 9'd0, 10'd1, 9'd1, 6'h2A);
    vectors++; if (we !== 1'b1 || waddr !== 19'd5 || wdata !== 6'h2A || busy !== 1'b1) begin
      miscompares++; $display("FAIL b2b_accept we=%b waddr=%0d wdata=%0d busy=%b required 1 5 42 1", we, waddr, wdata, busy); end
    step();
    vectors++; if (done !== 1'b1 || we !== 1'b0) begin
      miscompares++; $display("FAIL b2b_fill_done done=%b we=%b required 1 0", done, we); end
    step();
  endtask

  task automatic test_reset_abort();
    issue(2'b00, 2'd1, 10'd10, 9'd20, 10'd0, 9'd0, 6'd0);
    for (int c = 1; c < 8; c++) step();
    rst = 1'b1;
    step();
    vectors++; if (we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++; $display("FAIL abort_flags we=%b busy=%b done=%b required 0 0 0", we, busy, done); end
    vectors++; if (rom_addr !== 16'd0 || rom_sel !== 2'd0 || waddr !== 19'd0 || wdata !== 6'd0) begin
      miscompares++; $display("FAIL abort_outs rom_addr=%0d rom_sel=%0d waddr=%0d wdata=%0d required all 0",
                              rom_addr, rom_sel, waddr, wdata); end
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      vectors++; if (done !== 1'b0 || we !== 1'b0) begin
        miscompares++; $display("FAIL abort_after cycle%0d done=%b we=%b required 0 0", c, done, we); end
    end
  endtask

  initial begin
    init_rom();
    test_reset();
    test_draw();
    test_transparent();
    test_clip();
    test_fill();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
